node_interface: RTL and testbench

//   Node-side endpoint of the router port link (free/put/8-bit payload serial protocol).
//   TX path: queues 32-bit pkt_t words from the node and serializes each as 4 bytes to the router.
//   RX path: deserializes 4-byte bursts from the router into pkt_t and queues them for the node.

---
 rtl/node_interface.sv | 259 +++++++++++++++++++++++++
 tb/tb_node_interface.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_interface.sv
// ---------------------------------------------------------------------------
// node_interface
//   Node-side endpoint of a router port link. The link moves one 32-bit
//   packet as four consecutive bytes (MSB first) qualified by a put strobe,
//   with a free flag flowing the other way that is looked at only before a
//   packet starts.
//
//   TX path: node packets are queued in a small FIFO and serialized toward
//            the router whenever the router reports free.
//   RX path: byte bursts from the router are reassembled into packets and
//            queued for the node. Short bursts and packets that arrive while
//            the queue is full are dropped and flagged on rx_err.
//
// Parameters
//   TXDEPTH  TX packet FIFO depth (>= 2)
//   RXDEPTH  RX packet FIFO depth (>= 2)
//
// Ports
//   clk, rst_b                    clock (posedge) / async active-low reset
//   pkt_in, pkt_in_valid/ready    node -> TX FIFO, valid/ready handshake
//   pkt_out, pkt_out_valid/ready  RX FIFO head -> node, valid/ready handshake
//   free_rtr                      router can accept a whole packet
//   put_rtr, payload_rtr          byte stream toward the router
//   free_node                     this block can accept a whole packet
//   put_node, payload_node        byte stream from the router
//   rx_err                        one-cycle pulse when an RX packet is dropped
// ---------------------------------------------------------------------------
module node_interface #(
  parameter int TXDEPTH = 4,
  parameter int RXDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_valid,
  output logic        pkt_in_ready,
  output logic [31:0] pkt_out,
  output logic        pkt_out_valid,
  input  logic        pkt_out_ready,
  input  logic        free_rtr,
  output logic        put_rtr,
  output logic [7:0]  payload_rtr,
  output logic        free_node,
  input  logic        put_node,
  input  logic [7:0]  payload_node,
  output logic        rx_err
);

  localparam int TXPW = $clog2(TXDEPTH);
  localparam int TXCW = $clog2(TXDEPTH + 1);
  localparam int RXPW = $clog2(RXDEPTH);
  localparam int RXCW = $clog2(RXDEPTH + 1);

  localparam logic [TXPW-1:0] TX_LAST = TXPW'(TXDEPTH - 1);
  localparam logic [TXCW-1:0] TX_FULL = TXCW'(TXDEPTH);
  localparam logic [RXPW-1:0] RX_LAST = RXPW'(RXDEPTH - 1);
  localparam logic [RXCW-1:0] RX_FULL = RXCW'(RXDEPTH);
  localparam logic [RXCW-1:0] RX_ONE  = RXCW'(1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_state_e;

  // ---------------- TX path ----------------
  logic [31:0]     tx_mem_q [TXDEPTH];
  logic [TXPW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TXPW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TXCW-1:0] tx_count_q,  tx_count_d;
  tx_state_e       tx_state_q,  tx_state_d;
  logic [1:0]      tx_cnt_q,    tx_cnt_d;
  logic [31:0]     tx_shift_q,  tx_shift_d;
  logic            put_rtr_q,   put_rtr_d;
  logic [7:0]      payload_rtr_q, payload_rtr_d;
  logic            tx_push, tx_pop;

  assign pkt_in_ready = (tx_count_q != TX_FULL);
  assign tx_push      = pkt_in_valid && pkt_in_ready;

  // Serializer. The head packet is popped into the shift register as byte 0
  // goes out; the GAP state guarantees one idle put cycle between packets.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_shift_d    = tx_shift_q;
    put_rtr_d     = put_rtr_q;
    payload_rtr_d = payload_rtr_q;
    tx_pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        put_rtr_d     = 1'b0;
        payload_rtr_d = '0;
        if ((tx_count_q != '0) && free_rtr) begin
          tx_pop        = 1'b1;
          put_rtr_d     = 1'b1;
          payload_rtr_d = tx_mem_q[tx_rd_ptr_q][31:24];
          tx_shift_d    = {tx_mem_q[tx_rd_ptr_q][23:0], 8'h00};
          tx_cnt_d      = 2'd1;
          tx_state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        payload_rtr_d = tx_shift_q[31:24];
        tx_shift_d    = {tx_shift_q[23:0], 8'h00};
        tx_cnt_d      = tx_cnt_q + 2'd1;
        if (tx_cnt_q == 2'd3) begin
          tx_state_d = TX_GAP;
        end
      end
      TX_GAP: begin
        put_rtr_d     = 1'b0;
        payload_rtr_d = '0;
        tx_cnt_d      = '0;
        tx_state_d    = TX_IDLE;
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push) begin
      tx_wr_ptr_d = (tx_wr_ptr_q == TX_LAST) ? '0 : tx_wr_ptr_q + TXPW'(1);
    end
    if (tx_pop) begin
      tx_rd_ptr_d = (tx_rd_ptr_q == TX_LAST) ? '0 : tx_rd_ptr_q + TXPW'(1);
    end
    if (tx_push && !tx_pop) begin
      tx_count_d = tx_count_q + TXCW'(1);
    end else if (!tx_push && tx_pop) begin
      tx_count_d = tx_count_q - TXCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= pkt_in;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_count_q    <= '0;
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_shift_q    <= '0;
      put_rtr_q     <= 1'b0;
      payload_rtr_q <= '0;
    end else begin
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_count_q    <= tx_count_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_shift_q    <= tx_shift_d;
      put_rtr_q     <= put_rtr_d;
      payload_rtr_q <= payload_rtr_d;
    end
  end

  assign put_rtr     = put_rtr_q;
  assign payload_rtr = payload_rtr_q;

  // ---------------- RX path ----------------
  logic [31:0]     rx_mem_q [RXDEPTH];
  logic [RXPW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RXPW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RXCW-1:0] rx_count_q,  rx_count_d;
  logic [1:0]      rx_cnt_q,    rx_cnt_d;
  logic [23:0]     rx_shift_q,  rx_shift_d;
  logic            rx_err_q,    rx_err_d;
  logic            free_node_q, free_node_d;
  logic [31:0]     pkt_out_q,   pkt_out_d;
  logic [31:0]     rx_word;
  logic            rx_pop, rx_done, rx_push;

  // Assembler plus FIFO bookkeeping. Only the first three bytes are kept in
  // the shift register; the fourth is taken straight from the link so the
  // word can be pushed on the same edge it completes.
  always_comb begin
    rx_word     = {rx_shift_q, payload_node};
    rx_pop      = (rx_count_q != '0) && pkt_out_ready;
    rx_done     = put_node && (rx_cnt_q == 2'd3);
    // A full FIFO still takes the word if the node frees a slot this edge.
    rx_push     = rx_done && ((rx_count_q != RX_FULL) || rx_pop);
    rx_err_d    = (rx_done && !rx_push) || (!put_node && (rx_cnt_q != 2'd0));
    rx_shift_d  = put_node ? {rx_shift_q[15:0], payload_node} : rx_shift_q;
    rx_cnt_d    = (put_node && !rx_done) ? rx_cnt_q + 2'd1 : 2'd0;

    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push) begin
      rx_wr_ptr_d = (rx_wr_ptr_q == RX_LAST) ? '0 : rx_wr_ptr_q + RXPW'(1);
    end
    if (rx_pop) begin
      rx_rd_ptr_d = (rx_rd_ptr_q == RX_LAST) ? '0 : rx_rd_ptr_q + RXPW'(1);
    end
    if (rx_push && !rx_pop) begin
      rx_count_d = rx_count_q + RXCW'(1);
    end else if (!rx_push && rx_pop) begin
      rx_count_d = rx_count_q - RXCW'(1);
    end

    // Registered head: when no older entry survives this edge, the new head
    // is the word being written now, which is not yet in the array.
    if (rx_count_d == '0) begin
      pkt_out_d = '0;
    end else if ((rx_count_q == '0) || ((rx_count_q == RX_ONE) && rx_pop)) begin
      pkt_out_d = rx_word;
    end else begin
      pkt_out_d = rx_mem_q[rx_rd_ptr_d];
    end

    // A packet still being assembled reserves a slot.
    free_node_d = (int'(rx_count_d) + int'(rx_cnt_d != 2'd0)) < RXDEPTH;
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wr_ptr_q] <= rx_word;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_err_q    <= 1'b0;
      free_node_q <= 1'b1;
      pkt_out_q   <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_err_q    <= rx_err_d;
      free_node_q <= free_node_d;
      pkt_out_q   <= pkt_out_d;
    end
  end

  assign pkt_out       = pkt_out_q;
  assign pkt_out_valid = (rx_count_q != '0);
  assign free_node     = free_node_q;
  assign rx_err        = rx_err_q;

endmodule

// File: tb/tb_node_interface.sv
// ---------------------------------------------------------------------------
// tb_node_interface
//   Randomized and directed stimulus for node_interface. Expected TX words
//   are queued as the node hands them over; a link monitor rebuilds bursts
//   and checks them, along with burst timing and backpressure, against a
//   packet-level model. An RX monitor models the router-to-node direction
//   with a packet queue and a list of bytes in flight.
// ---------------------------------------------------------------------------
module tb_node_interface;
  localparam int TXDEPTH = 4;
  localparam int RXDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] pkt_in;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [31:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic        free_rtr;
  logic        put_rtr;
  logic [7:0]  payload_rtr;
  logic        free_node;
  logic        put_node;
  logic [7:0]  payload_node;
  logic        rx_err;

  node_interface #(.TXDEPTH(TXDEPTH), .RXDEPTH(RXDEPTH)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .pkt_in        (pkt_in),
    .pkt_in_valid  (pkt_in_valid),
    .pkt_in_ready  (pkt_in_ready),
    .pkt_out       (pkt_out),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out_ready (pkt_out_ready),
    .free_rtr      (free_rtr),
    .put_rtr       (put_rtr),
    .payload_rtr   (payload_rtr),
    .free_node     (free_node),
    .put_node      (put_node),
    .payload_node  (payload_node),
    .rx_err        (rx_err)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_failed   = 0;
  logic [31:0] tx_exp [$];
  int free_mode = 1;   // 0: low, 1: high, 2: random
  int rdy_mode  = 0;   // 0: low, 1: random, 2: high

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_compared++;
    n_failed++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic setFree(input int m);
    @(posedge clk); #1;
    free_mode = m;
  endtask

  task automatic setReady(input int m);
    @(posedge clk); #1;
    rdy_mode = m;
  endtask

  // Node offers one packet and holds it until accepted.
  task automatic applyStimulus(input logic [31:0] word);
    int waited;
    waited = 0;
    @(posedge clk); #2;
    pkt_in       = word;
    pkt_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (pkt_in_ready) break;
      waited++;
      if (waited > 300) break;
    end
    if (waited > 300) reportTimeout("tx_accept");
    else tx_exp.push_back(word);
    @(posedge clk); #2;
    pkt_in_valid = 1'b0;
    pkt_in       = '0;
  endtask

  // Router sends nbytes of word (MSB first), optionally waiting for free_node.
  task automatic sendBurst(input logic [31:0] word, input int nbytes, input bit honor);
    int waited;
    waited = 0;
    if (honor) begin
      @(negedge clk);
      while (!free_node && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!free_node) begin
        reportTimeout("rx_free_node");
        return;
      end
    end
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #2;
      put_node     = 1'b1;
      payload_node = word[31-8*i -: 8];
    end
    @(posedge clk); #2;
    put_node     = 1'b0;
    payload_node = '0;
  endtask

  // Background drivers for free_rtr and pkt_out_ready.
  initial begin
    free_rtr      = 1'b0;
    pkt_out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (free_mode)
        0:       free_rtr = 1'b0;
        1:       free_rtr = 1'b1;
        default: free_rtr = ($urandom_range(0, 1) == 1);
      endcase
      case (rdy_mode)
        0:       pkt_out_ready = 1'b0;
        2:       pkt_out_ready = 1'b1;
        default: pkt_out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // TX monitor. Inputs seen at a negedge are the ones the next edge samples,
  // so each iteration first judges the edge just passed, then snapshots.
  // A burst must start exactly when packets are waiting, the router was free
  // at that edge and the link has been idle for at least one cycle.
  initial begin : tx_monitor
    int acc, started, byte_idx, low_run;
    logic pend, prev_free, exp_put;
    logic [31:0] cur;
    acc = 0; started = 0; byte_idx = 0; low_run = 1;
    pend = 1'b0; prev_free = 1'b0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        acc = 0; started = 0; byte_idx = 0; low_run = 1;
        tx_exp.delete();
        checkOutput("rst_put_rtr", put_rtr, 0);
        checkOutput("rst_payload_rtr", payload_rtr, 0);
        checkOutput("rst_pkt_in_ready", pkt_in_ready, 1);
      end else begin
        exp_put = (byte_idx != 0) || (((acc - started) > 0) && prev_free && (low_run >= 1));
        checkOutput("tx_put_rtr", put_rtr, exp_put);
        if (put_rtr) begin
          if (byte_idx == 0) begin
            started++;
            checkOutput("tx_burst_has_packet", tx_exp.size() != 0, 1);
            cur = (tx_exp.size() != 0) ? tx_exp.pop_front() : '0;
          end
          checkOutput("tx_payload", payload_rtr, cur[31-8*byte_idx -: 8]);
          byte_idx = (byte_idx + 1) % 4;
          low_run  = 0;
        end else begin
          byte_idx = 0;
          low_run++;
        end
        if (pend) acc++;
        checkOutput("tx_ready", pkt_in_ready, (acc - started) < TXDEPTH);
      end
      pend      = pkt_in_valid && pkt_in_ready && rst_b;
      prev_free = free_rtr;
    end
  end

  // RX monitor: packet queue plus bytes of the burst in flight.
  initial begin : rx_monitor
    logic [31:0] rx_q [$];
    logic [7:0]  rx_bytes [$];
    logic        s_put, s_rdy, err_exp;
    logic [7:0]  s_byte;
    logic [31:0] w;
    int          size_before;
    s_put = 1'b0; s_rdy = 1'b0; s_byte = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        rx_q.delete();
        rx_bytes.delete();
        checkOutput("rst_pkt_out_valid", pkt_out_valid, 0);
        checkOutput("rst_pkt_out", pkt_out, 0);
        checkOutput("rst_free_node", free_node, 1);
        checkOutput("rst_rx_err", rx_err, 0);
      end else begin
        err_exp     = 1'b0;
        size_before = rx_q.size();
        if (s_rdy && size_before > 0) void'(rx_q.pop_front());
        if (s_put) begin
          rx_bytes.push_back(s_byte);
          if (rx_bytes.size() == 4) begin
            w = {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]};
            rx_bytes.delete();
            if (size_before == RXDEPTH && !s_rdy) err_exp = 1'b1;
            else rx_q.push_back(w);
          end
        end else if (rx_bytes.size() != 0) begin
          rx_bytes.delete();
          err_exp = 1'b1;
        end
        checkOutput("rx_err", rx_err, err_exp);
        checkOutput("rx_pkt_out_valid", pkt_out_valid, rx_q.size() != 0);
        if (rx_q.size() != 0) checkOutput("rx_pkt_out", pkt_out, rx_q[0]);
        checkOutput("rx_free_node", free_node,
                    (rx_q.size() + ((rx_bytes.size() != 0) ? 1 : 0)) < RXDEPTH);
      end
      s_put  = put_node && rst_b;
      s_byte = payload_node;
      s_rdy  = pkt_out_ready && rst_b;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main_seq
    int n;
    rst_b        = 1'b0;
    pkt_in       = '0;
    pkt_in_valid = 1'b0;
    put_node     = 1'b0;
    payload_node = '0;
    repeat (3) @(posedge clk);
    #7 rst_b = 1'b1;

    $display("[TB] single TX packet");
    applyStimulus(32'hA312_3456);
    waitCycles(10);

    $display("[TB] TX held off by free_rtr");
    setFree(0);
    applyStimulus(32'h0BAD_F00D);
    waitCycles(10);
    setFree(1);
    waitCycles(8);

    $display("[TB] TX FIFO fill and drain");
    setFree(0);
    fork
      for (int i = 0; i < TXDEPTH + 1; i++) applyStimulus(32'h1100_0000 | 32'(i));
      begin
        waitCycles(20);
        setFree(1);
      end
    join
    waitCycles(30);

    $display("[TB] single RX packet");
    setReady(0);
    sendBurst(32'h51DE_AD01, 4, 1'b1);
    waitCycles(3);
    setReady(2);
    waitCycles(3);

    $display("[TB] truncated RX burst");
    sendBurst(32'hCAFE_0000, 2, 1'b1);
    sendBurst(32'h1234_5678, 4, 1'b1);
    waitCycles(3);

    $display("[TB] RX FIFO fill and overflow");
    setReady(0);
    for (int i = 0; i < RXDEPTH; i++) sendBurst(32'h2200_0000 | 32'(i), 4, 1'b1);
    sendBurst(32'hDEAD_BEEF, 4, 1'b0);
    waitCycles(2);
    setReady(2);
    setReady(0);
    waitCycles(3);
    setReady(2);
    waitCycles(8);

    $display("[TB] random traffic");
    setFree(2);
    setReady(1);
    fork
      for (int i = 0; i < 25; i++) applyStimulus($urandom);
      for (int i = 0; i < 25; i++) begin
        n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
        sendBurst($urandom, n, $urandom_range(0, 9) != 0);
      end
    join
    setFree(1);
    setReady(2);
    waitCycles(60);

    $display("[TB] reset mid-burst");
    applyStimulus(32'h7777_8888);
    @(posedge clk); #2;
    put_node = 1'b1; payload_node = 8'h9A;
    @(posedge clk); #2;
    payload_node = 8'hBC;
    @(posedge clk); #2;
    rst_b = 1'b0;
    put_node = 1'b0; payload_node = '0;
    repeat (2) @(posedge clk);
    #7 rst_b = 1'b1;
    applyStimulus(32'h0102_0304);
    sendBurst(32'hA5A5_5A5A, 4, 1'b1);
    waitCycles(15);

    checkOutput("tx_queue_drained", tx_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
